// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with per-register pending scoreboard and display nibble tap.
// Build option REGFILE_BYPASS_EN: write-to-read bypass on both read ports.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned TAP_BASE = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Write_register,
    input  logic [DATA_W-1:0] Write_data,
    input  logic [ADDR_W-1:0] Read_register1,
    input  logic [ADDR_W-1:0] Read_register2,
    output logic [DATA_W-1:0] Read_data1,
    output logic [DATA_W-1:0] Read_data2,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] Reserve_register,
    output logic              Read_ready1,
    output logic              Read_ready2,
    output logic [ADDR_W:0]   Pending_count,
    output logic [15:0]       tap_data
);

    localparam int unsigned NumRegs = 1 << ADDR_W;

    logic [DATA_W-1:0] rf_q [NumRegs];
    logic [NumRegs-1:0] pending_q, pending_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [15:0]        tap_q;

    logic wr_en, res_en, set_ev, clr_ev;

    // Register 0 is never a write or reserve target.
    assign wr_en  = RegWrite && (Write_register != '0);
    assign res_en = Reserve && (Reserve_register != '0);

    always_comb begin
        pending_d = pending_q;
        set_ev    = 1'b0;
        clr_ev    = 1'b0;
        if (wr_en) begin
            pending_d[Write_register] = 1'b0;
        end
        if (res_en) begin
            pending_d[Reserve_register] = 1'b1;
        end
        if (res_en && !pending_q[Reserve_register]) begin
            set_ev = 1'b1;
        end
        // A same-address reservation keeps the bit set, so no clear happens.
        if (wr_en && pending_q[Write_register] &&
            !(res_en && (Reserve_register == Write_register))) begin
            clr_ev = 1'b1;
        end
        count_d = count_q;
        case ({set_ev, clr_ev})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                rf_q[i] <= '0;
            end
            pending_q <= '0;
            count_q   <= '0;
            tap_q     <= '0;
        end else begin
            if (wr_en) begin
                rf_q[Write_register] <= Write_data;
            end
            pending_q <= pending_d;
            count_q   <= count_d;
            tap_q     <= {rf_q[TAP_BASE][3:0], rf_q[TAP_BASE+1][3:0],
                          rf_q[TAP_BASE+2][3:0], rf_q[TAP_BASE+3][3:0]};
        end
    end

    always_comb begin
        Read_data1  = rf_q[Read_register1];
        Read_ready1 = ~pending_q[Read_register1];
        Read_data2  = rf_q[Read_register2];
        Read_ready2 = ~pending_q[Read_register2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (Write_register == Read_register1)) begin
            Read_data1  = Write_data;
            Read_ready1 = !(res_en && (Reserve_register == Read_register1));
        end
        if (wr_en && (Write_register == Read_register2)) begin
            Read_data2  = Write_data;
            Read_ready2 = !(res_en && (Reserve_register == Read_register2));
        end
`endif
        if (Read_register1 == '0) begin
            Read_data1  = '0;
            Read_ready1 = 1'b1;
        end
        if (Read_register2 == '0) begin
            Read_data2  = '0;
            Read_ready2 = 1'b1;
        end
    end

    assign Pending_count = count_q;
    assign tap_data      = tap_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [4:0]  Read_register1, Read_register2;
    logic [31:0] Read_data1, Read_data2;
    logic        Reserve;
    logic [4:0]  Reserve_register;
    logic        Read_ready1, Read_ready2;
    logic [5:0]  Pending_count;
    logic [15:0] tap_data;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_scoreboard dut (
        .clk              (clk),
        .reset            (reset),
        .RegWrite         (RegWrite),
        .Write_register   (Write_register),
        .Write_data       (Write_data),
        .Read_register1   (Read_register1),
        .Read_register2   (Read_register2),
        .Read_data1       (Read_data1),
        .Read_data2       (Read_data2),
        .Reserve          (Reserve),
        .Reserve_register (Reserve_register),
        .Read_ready1      (Read_ready1),
        .Read_ready2      (Read_ready2),
        .Pending_count    (Pending_count),
        .tap_data         (tap_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0;
        Reserve  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        RegWrite       = 1'b1;
        Write_register = a;
        Write_data     = d;
    endtask

    task automatic rsv(input logic [4:0] a);
        Reserve          = 1'b1;
        Reserve_register = a;
    endtask

    initial begin
        reset = 1'b0;
        RegWrite = 1'b0; Write_register = '0; Write_data = '0;
        Reserve = 1'b0; Reserve_register = '0;
        Read_register1 = '0; Read_register2 = '0;
        tick();
        tick();
        reset = 1'b1;
        Read_register1 = 5'd5;
        #1;
        check_eq("reset_count", 32'(Pending_count), 32'd0);
        check_eq("reset_tap", 32'(tap_data), 32'd0);
        check_eq("reset_r5", Read_data1, 32'd0);

        wr(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        Read_register1 = 5'd5; Read_register2 = 5'd0;
        #1;
        check_eq("r5_read", Read_data1, 32'hDEADBEEF);
        check_eq("r0_read", Read_data2, 32'd0);
        check_eq("count_after_wr", 32'(Pending_count), 32'd0);

        wr(5'd0, 32'h12345678);
        tick();
        idle();
        Read_register1 = 5'd0;
        #1;
        check_eq("r0_after_wr", Read_data1, 32'd0);
        check_eq("r0_ready", 32'(Read_ready1), 32'd1);
        rsv(5'd0);
        tick();
        idle();
        #1;
        check_eq("r0_rsv_count", 32'(Pending_count), 32'd0);
        check_eq("r0_rsv_ready", 32'(Read_ready1), 32'd1);

        rsv(5'd8);
        tick();
        rsv(5'd9);
        tick();
        idle();
        Read_register1 = 5'd8; Read_register2 = 5'd9;
        #1;
        check_eq("count_2", 32'(Pending_count), 32'd2);
        check_eq("r8_not_ready", 32'(Read_ready1), 32'd0);
        check_eq("r9_not_ready", 32'(Read_ready2), 32'd0);

        wr(5'd8, 32'h88);
        rsv(5'd10);
        tick();
        idle();
        Read_register1 = 5'd8; Read_register2 = 5'd10;
        #1;
        check_eq("count_net0", 32'(Pending_count), 32'd2);
        check_eq("r8_ready", 32'(Read_ready1), 32'd1);
        check_eq("r8_data", Read_data1, 32'h88);
        check_eq("r10_not_ready", 32'(Read_ready2), 32'd0);

        wr(5'd9, 32'h99);
        tick();
        wr(5'd10, 32'hAA);
        tick();
        idle();
        #1;
        check_eq("count_drained", 32'(Pending_count), 32'd0);

        rsv(5'd7);
        wr(5'd7, 32'hA5);
        tick();
        idle();
        Read_register1 = 5'd7;
        #1;
        check_eq("r7_data", Read_data1, 32'hA5);
        check_eq("r7_pending", 32'(Read_ready1), 32'd0);
        check_eq("r7_count1", 32'(Pending_count), 32'd1);
        wr(5'd7, 32'hA6);
        tick();
        idle();
        #1;
        check_eq("r7_ready", 32'(Read_ready1), 32'd1);
        check_eq("r7_count0", 32'(Pending_count), 32'd0);

        wr(5'd12, 32'h1111);
        tick();
        wr(5'd12, 32'h55AA);
        Read_register1 = 5'd12;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("r12_same_cycle", Read_data1, 32'h55AA);
`else
        check_eq("r12_same_cycle", Read_data1, 32'h1111);
`endif
        check_eq("r12_ready", 32'(Read_ready1), 32'd1);
        tick();
        idle();
        #1;
        check_eq("r12_after", Read_data1, 32'h55AA);

        wr(5'd19, 32'h1);
        tick();
        wr(5'd20, 32'h2);
        tick();
        wr(5'd21, 32'h3);
        tick();
        wr(5'd22, 32'h4);
        tick();
        idle();
        #1;
        check_eq("tap_lag", 32'(tap_data), 32'h1230);
        tick();
        check_eq("tap_full", 32'(tap_data), 32'h1234);

        rsv(5'd3);
        tick();
        idle();
        #1;
        check_eq("pre_reset_count", 32'(Pending_count), 32'd1);
        reset = 1'b0;
        wr(5'd19, 32'hF);
        rsv(5'd4);
        tick();
        reset = 1'b1;
        idle();
        Read_register1 = 5'd19; Read_register2 = 5'd5;
        #1;
        check_eq("rst_count", 32'(Pending_count), 32'd0);
        check_eq("rst_tap", 32'(tap_data), 32'd0);
        check_eq("rst_r19_lost", Read_data1, 32'd0);
        check_eq("rst_r5", Read_data2, 32'd0);
        Read_register1 = 5'd3; Read_register2 = 5'd4;
        #1;
        check_eq("rst_r3_ready", 32'(Read_ready1), 32'd1);
        check_eq("rst_r4_ready", 32'(Read_ready2), 32'd1);
        tick();
        check_eq("rst_tap_next", 32'(tap_data), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the pipelined MIPS core, placed in the decode stage. It provides two combinational read ports, one clocked write port, and a per-register pending scoreboard so the hazard unit can stall on in-flight producers (e.g. load-use). It also drives a registered 16-bit nibble tap for the board display.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; the file holds 2^ADDR_W entries, and entry 0 is hardwired zero
- TAP_BASE, 19, first of four consecutive registers mirrored on tap_data; must satisfy 1 ≤ TAP_BASE ≤ 2^ADDR_W−4

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; sampled on the clk rising edge
- RegWrite  in  1  write enable
- Write_register  in  ADDR_W  write address
- Write_data  in  DATA_W  write data
- Read_register1, Read_register2  in  ADDR_W  read addresses
- Read_data1, Read_data2  out  DATA_W  combinational read data
- Reserve  in  1  marks Reserve_register as having an in-flight producer
- Reserve_register  in  ADDR_W  register to mark pending
- Read_ready1, Read_ready2  out  1  combinational; 1 when the addressed register holds committed data
- Pending_count  out  ADDR_W+1  registered count of pending registers
- tap_data  out  16  registered concatation {RF[TAP_BASE][3:0], RF[TAP_BASE+1][3:0], RF[TAP_BASE+2][3:0], RF[TAP_BASE+3][3:0]}

## Operation
- **Reset** (reset=0 at an edge):
  - All entries, the pending bits, Pending_count and tap_data become 0.
  - Reset overrides RegWrite and Reserve in the same cycle.
- **Register 0:**
  - Always reads 0 and always reports ready.
  - Writes to it and reservations of it are ignored.
- **Write:** when RegWrite=1 and Write_register≠0, the entry takes Write_data at the edge.
- **Read:**
  - Read_dataN = RF[Read_registerN], purely combinational.
  - Both ports may read the same address.
- **Scoreboard**, one pending bit per entry 1..2^ADDR_W−1:
  - Reserve with a nonzero address sets its bit at the edge.
  - A write to a nonzero address clears its bit.
  - Reserve and write to the same address in the same cycle: the reservation wins and the bit stays set (a newer producer).
  - Reserve of an already-pending register: the bit stays set.
  - A write to a non-pending register leaves all bits unchanged.
- **Readiness:** Read_readyN = ~pending[Read_registerN], or forced 1 when Read_registerN=0.
- **Pending_count:**
  - Increments by 1 only when a clear bit becomes set.
  - Decrements by 1 only when a set bit becomes clear.
  - When both happen in one cycle on different registers, the net change is 0.
  - It never wraps, because its maximum value is 2^ADDR_W−1.
- **Tap:** updated every cycle from the pre-edge array contents.

## Timing
- Read data and ready are zero-latency (combinational from address and current state).
- A write at edge k is visible on the read ports after edge k. Same-cycle visibility depends on the configuration below.
- A reservation at edge k drops Read_ready after edge k.
- Pending_count reflects the scoreboard after the same edge.
- tap_data lags by one cycle: a write at edge k appears on tap_data after edge k+1.
- Reset asserted mid-operation takes effect at the next edge and discards any concurrent write or reserve.

## Configuration
Macro: REGFILE_BYPASS_EN.

Defined:
- Write-to-read bypass is enabled. If RegWrite=1, Write_register≠0 and Write_register=Read_registerN, then Read_dataN=Write_data in the same cycle.
- Read_readyN is forced to 1 unless the same register is also being reserved that cycle.

Undefined:
- There is no bypass. Read_dataN returns the old contents until the edge.
- Read_readyN follows the pending bit only.

The scoreboard, count and tap behave identically in both builds.

## Test plan
- Reset, then write 0xDEADBEEF to r5; read r5 and r0 next cycle → Read_data1=0xDEADBEEF, Read_data2=0; Pending_count=0.
- Write 0x12345678 to r0, then read r0 → 0, Read_ready=1. Reserve r0 → Pending_count stays 0.
- Reserve r8 and r9 on consecutive cycles → Pending_count=2, Read_ready for r8 =0. Then write r8 while reserving r10 in the same cycle → Pending_count stays 2, r8 ready=1, r10 ready=0.
- Reserve r7 and write r7=0xA5 in the same cycle → r7 reads 0xA5, r7 is still pending, Pending_count=1. Then write r7 again → not pending, Pending_count=0.
- Same-cycle read of r12 while writing r12=0x55AA: with REGFILE_BYPASS_EN → Read_data1=0x55AA that cycle; without it → previous value, then 0x55AA after the edge.
- Write r19..r22 = 0x1,0x2,0x3,0x4 at edge k → tap_data=0x1234 after edge k+1. Assert reset during a write → all registers, tap_data and Pending_count are 0 after the edge, and the write is lost.
